// File: rtl/button_conditioner_pkg.sv
// Shared definitions for the push-button conditioner: FSM encodings and
// clock-rate helpers used to derive cycle-count parameters.
package button_conditioner_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_HOLD   = 2'd1,
    ST_REPEAT = 2'd2
  } bc_state_e;

  localparam int CLK_HZ = 27_000_000;

  function automatic int ms_to_cycles(input int ms);
    return (CLK_HZ / 1000) * ms;
  endfunction

endpackage

// File: rtl/bc_sync.sv
// Multi-flop synchroniser for an asynchronous single-bit input; every stage
// is loaded with RST_VAL so nothing spurious propagates out of reset.
module bc_sync #(
  parameter int STAGES  = 2,
  parameter bit RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= {STAGES{RST_VAL}};
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d};
    end
  end

  assign q = sync_q[STAGES-1];

endmodule

// File: rtl/button_conditioner.sv
// Push-button conditioner: synchronise, debounce, then emit press/release
// strobes and auto-repeat ticks while the button stays held.
module button_conditioner
  import button_conditioner_pkg::*;
#(
  parameter bit ACTIVE_LOW      = 1'b1,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = ms_to_cycles(10),
  parameter int HOLD_CYCLES     = ms_to_cycles(500),
  parameter int REPEAT_CYCLES   = ms_to_cycles(100)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_raw,
  output logic pressed,
  output logic press_pulse,
  output logic release_pulse,
  output logic repeat_pulse
);

  localparam int DB_W   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int HC_MAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
  localparam int HC_W   = $clog2(HC_MAX + 1);

  localparam logic [DB_W-1:0] DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [HC_W-1:0] HOLD_LAST = HC_W'(HOLD_CYCLES - 1);
  localparam logic [HC_W-1:0] REP_LAST  = HC_W'(REPEAT_CYCLES - 1);

  logic            lvl;
  logic            s;
  logic            pressed_q;
  logic [DB_W-1:0] db_cnt_q, db_cnt_d;
  logic            db_fire;
  logic            press_evt, release_evt;
  logic [HC_W-1:0] hold_cnt_q;
  bc_state_e       state_q;
  logic            press_q, release_q, repeat_q;

  // After normalisation 1 always means "pressed", so the synchroniser resets to 0.
  assign lvl = btn_raw ^ ACTIVE_LOW;

  bc_sync #(
    .STAGES (SYNC_STAGES),
    .RST_VAL(1'b0)
  ) u_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .d    (lvl),
    .q    (s)
  );

  // Firing at >= DB_LAST keeps the counter from ever passing DB_LAST, so it cannot wrap.
  always_comb begin
    db_cnt_d = db_cnt_q;
    db_fire  = 1'b0;
    if (s == pressed_q) begin
      db_cnt_d = '0;
    end else if (db_cnt_q >= DB_LAST) begin
      db_cnt_d = '0;
      db_fire  = 1'b1;
    end else begin
      db_cnt_d = db_cnt_q + 1'b1;
    end
  end

  assign press_evt   = db_fire & s;
  assign release_evt = db_fire & ~s;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pressed_q  <= 1'b0;
      db_cnt_q   <= '0;
      hold_cnt_q <= '0;
      state_q    <= ST_IDLE;
      press_q    <= 1'b0;
      release_q  <= 1'b0;
      repeat_q   <= 1'b0;
    end else begin
      pressed_q <= db_fire ? s : pressed_q;
      db_cnt_q  <= db_cnt_d;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      repeat_q  <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (press_evt) begin
            state_q    <= ST_HOLD;
            hold_cnt_q <= '0;
            press_q    <= 1'b1;
          end
        end
        ST_HOLD: begin
          if (release_evt) begin
            state_q    <= ST_IDLE;
            hold_cnt_q <= '0;
            release_q  <= 1'b1;
          end else if (hold_cnt_q == HOLD_LAST) begin
            // With repeat disabled the counter parks here until release.
            if (REPEAT_CYCLES != 0) begin
              state_q    <= ST_REPEAT;
              hold_cnt_q <= '0;
              repeat_q   <= 1'b1;
            end
          end else begin
            hold_cnt_q <= hold_cnt_q + 1'b1;
          end
        end
        ST_REPEAT: begin
          if (release_evt) begin
            state_q    <= ST_IDLE;
            hold_cnt_q <= '0;
            release_q  <= 1'b1;
          end else if (hold_cnt_q == REP_LAST) begin
            hold_cnt_q <= '0;
            repeat_q   <= 1'b1;
          end else begin
            hold_cnt_q <= hold_cnt_q + 1'b1;
          end
        end
        default: begin
          state_q    <= ST_IDLE;
          hold_cnt_q <= '0;
        end
      endcase
    end
  end

  assign pressed       = pressed_q;
  assign press_pulse   = press_q;
  assign release_pulse = release_q;
  assign repeat_pulse  = repeat_q;

endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench for button_conditioner: one instance with auto-repeat, one
// with auto-repeat disabled, sharing the same raw pin and reset.
module tb_button_conditioner;

  logic clk     = 1'b0;
  logic rst_n   = 1'b0;
  logic btn_raw = 1'b1;

  logic pressed, press_pulse, release_pulse, repeat_pulse;
  logic pressed1, press_pulse1, release_pulse1, repeat_pulse1;

  button_conditioner #(
    .ACTIVE_LOW(1'b1), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4),
    .HOLD_CYCLES(8), .REPEAT_CYCLES(3)
  ) dut (
    .clk(clk), .rst_n(rst_n), .btn_raw(btn_raw),
    .pressed(pressed), .press_pulse(press_pulse),
    .release_pulse(release_pulse), .repeat_pulse(repeat_pulse)
  );

  button_conditioner #(
    .ACTIVE_LOW(1'b1), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4),
    .HOLD_CYCLES(8), .REPEAT_CYCLES(0)
  ) dut_norep (
    .clk(clk), .rst_n(rst_n), .btn_raw(btn_raw),
    .pressed(pressed1), .press_pulse(press_pulse1),
    .release_pulse(release_pulse1), .repeat_pulse(repeat_pulse1)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Event log: cycle number of every strobe seen, sampled just after the edge.
  int press_q[$];
  int rel_q[$];
  int rep_q[$];
  int press1_total = 0;
  int rel1_total   = 0;
  int rep1_total   = 0;
  int excl_viol    = 0;
  bit any_prev     = 1'b0;

  always begin
    int n;
    @(posedge clk);
    #1;
    n = int'(press_pulse) + int'(release_pulse) + int'(repeat_pulse);
    if (press_pulse)   press_q.push_back(cyc);
    if (release_pulse) rel_q.push_back(cyc);
    if (repeat_pulse)  rep_q.push_back(cyc);
    if (n > 1 || (n > 0 && any_prev)) excl_viol++;
    any_prev = (n > 0);
    if (press_pulse1)   press1_total++;
    if (release_pulse1) rel1_total++;
    if (repeat_pulse1)  rep1_total++;
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end else begin
      $display("check %s: got %0d", tag, got);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  int e, r, bp, br, bq;

  initial begin
    // 1: reset with the button released, then idle
    rst_n   = 1'b0;
    btn_raw = 1'b1;
    cycles(3);
    check("rst_pressed", int'(pressed), 0);
    check("rst_pulses", int'({press_pulse, release_pulse, repeat_pulse}), 0);
    rst_n = 1'b1;
    cycles(20);
    check("idle_pressed", int'(pressed), 0);
    check("idle_events", press_q.size() + rel_q.size() + rep_q.size(), 0);

    // 3: bounce shorter than the debounce window
    bp = press_q.size();
    btn_raw = 1'b0; cycles(2);
    btn_raw = 1'b1; cycles(1);
    btn_raw = 1'b0; cycles(2);
    btn_raw = 1'b1; cycles(15);
    check("bounce_press", press_q.size() - bp, 0);
    check("bounce_pressed", int'(pressed), 0);

    // 2+4: clean press, long hold with repeats, release landing on a repeat tick
    bp = press_q.size(); br = rel_q.size(); bq = rep_q.size();
    btn_raw = 1'b0;
    e = cyc;
    cycles(10);
    check("press_level", int'(pressed), 1);
    cycles(28);
    btn_raw = 1'b1;
    r = cyc;
    cycles(20);
    check("press_count", press_q.size() - bp, 1);
    check("press_latency", (press_q.size() > bp) ? press_q[bp] - e : -1, 6);
    check("rep_count", rep_q.size() - bq, 10);
    check("rep_first", (rep_q.size() > bq) ? rep_q[bq] - e : -1, 14);
    check("rep_second", (rep_q.size() > bq + 1) ? rep_q[bq+1] - e : -1, 17);
    check("rep_last", (rep_q.size() > bq) ? rep_q[rep_q.size()-1] - e : -1, 41);
    check("rel_count", rel_q.size() - br, 1);
    check("rel_latency", (rel_q.size() > br) ? rel_q[br] - r : -1, 6);
    check("rel_pressed", int'(pressed), 0);

    // 5: reset while the button is held
    btn_raw = 1'b0;
    rst_n   = 1'b0;
    cycles(3);
    check("rst_held_pressed", int'(pressed), 0);
    bp = press_q.size(); br = rel_q.size(); bq = rep_q.size();
    rst_n = 1'b1;
    e = cyc;
    cycles(5);
    check("rst_rel_no_event", press_q.size() + rel_q.size() + rep_q.size() - bp - br - bq, 0);
    cycles(3);
    check("held_press_count", press_q.size() - bp, 1);
    check("held_press_latency", (press_q.size() > bp) ? press_q[bp] - e : -1, 6);

    // 6: asynchronous reset in the middle of auto-repeat
    cycles(8);
    check("pre_rst_reps", rep_q.size() - bq, 1);
    check("pre_rst_pressed", int'(pressed), 1);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("async_outputs", int'({pressed, press_pulse, release_pulse, repeat_pulse}), 0);
    check("async_norep_pressed", int'(pressed1), 0);
    cycles(2);
    bp = press_q.size(); br = rel_q.size(); bq = rep_q.size();
    rst_n = 1'b1;
    e = cyc;
    cycles(5);
    check("rerel_no_event", press_q.size() + rel_q.size() + rep_q.size() - bp - br - bq, 0);
    cycles(3);
    check("rerel_press_latency", (press_q.size() > bp) ? press_q[bp] - e : -1, 6);
    btn_raw = 1'b1;
    cycles(12);
    check("rerel_release", rel_q.size() - br, 1);
    check("final_pressed", int'(pressed), 0);

    // Whole-run properties
    check("exclusive_strobes", excl_viol, 0);
    check("norep_repeats", rep1_total, 0);
    check("norep_presses", press1_total, 3);
    check("norep_releases", rel1_total, 2);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
